// File: rtl/vc_distributor.sv
// vc_distributor: buffers arbiter words in a small in-order FIFO and hands
// each one to the destination FIFO of its virtual channel, applying
// head-of-line blocking, almost-full backpressure and a sticky drop flag.
module vc_distributor #(
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [4:0] data_in,
    input  logic       valid_in,
    input  logic       fullVC0,
    input  logic       fullVC1,
    output logic       pause,
    output logic       pushVC0,
    output logic       pushVC1,
    output logic [3:0] dataOut_VC0,
    output logic [3:0] dataOut_VC1,
    output logic [7:0] count_VC0,
    output logic [7:0] count_VC1,
    output logic       overflow,
    output logic       idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STALL
    } state_t;

    state_t state, next_state;

    logic [4:0]    buffer [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] occupancy, next_occupancy;
    logic [4:0]    head;
    logic          head_full;
    logic          wr_en;
    logic          pop_en;
    logic          drop;

    // Pointers step through 0..DEPTH-1 and wrap, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // Write/pop/drop decisions; the head's full flag is looked at live this cycle.
    always_comb begin
        head           = buffer[rd_ptr];
        head_full      = head[4] ? fullVC1 : fullVC0;
        wr_en          = valid_in && (occupancy < OW'(DEPTH));
        drop           = valid_in && (occupancy == OW'(DEPTH));
        pop_en         = (occupancy != '0) && !head_full;
        next_occupancy = occupancy + OW'(wr_en) - OW'(pop_en);
    end

    // Holding buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) begin
                buffer[wr_ptr] <= data_in;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            occupancy <= next_occupancy;
        end
    end

    // Registered push strobes, payloads, counters, backpressure and drop flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause       <= 1'b0;
            pushVC0     <= 1'b0;
            pushVC1     <= 1'b0;
            dataOut_VC0 <= '0;
            dataOut_VC1 <= '0;
            count_VC0   <= '0;
            count_VC1   <= '0;
            overflow    <= 1'b0;
        end else begin
            pause   <= (int'(next_occupancy) >= AF_THRESH);
            pushVC0 <= pop_en && !head[4];
            pushVC1 <= pop_en && head[4];
            if (pop_en && !head[4]) begin
                dataOut_VC0 <= head[3:0];
                count_VC0   <= count_VC0 + 8'd1;
            end
            if (pop_en && head[4]) begin
                dataOut_VC1 <= head[3:0];
                count_VC1   <= count_VC1 + 8'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: empty -> IDLE, blocked head -> STALL, otherwise ACTIVE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE, STALL: begin
                if (pop_en && (occupancy == OW'(1)) && !wr_en) begin
                    next_state = IDLE;
                end else if ((occupancy != '0) && head_full) begin
                    next_state = STALL;
                end else if (occupancy != '0) begin
                    next_state = ACTIVE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign idle = (state == IDLE) && !pushVC0 && !pushVC1;

endmodule

// File: doc/vc_distributor.md
VC_DISTRIBUTOR -- requirements
Module: vc_distributor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries in the internal holding buffer.
REQ-002 SHALL have parameter AF_THRESH, default 3, the buffer occupancy at or above which pause asserts.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port data_in, input, 5, arbiter output word: [4] = VC id (0 = VC0, 1 = VC1), [3:0] = payload.
REQ-006 SHALL have port valid_in, input, 1, data_in carries a word this cycle.
REQ-007 SHALL have ports fullVC0 and fullVC1, input, 1 each, the destination FIFO for that VC is full.
REQ-008 SHALL have port pause, output, 1, registered backpressure to the arbiter.
REQ-009 SHALL have ports pushVC0 and pushVC1, output, 1 each, registered one-cycle push strobes to the destination FIFOs.
REQ-010 SHALL have ports dataOut_VC0 and dataOut_VC1, output, 4 each, registered payload for the matching push.
REQ-011 SHALL have ports count_VC0 and count_VC1, output, 8 each, words delivered per VC.
REQ-012 SHALL have port overflow, output, 1, sticky error flag: a word was dropped.
REQ-013 SHALL have port idle, output, 1, FSM is in IDLE and no push is asserted.

Function
REQ-014 SHALL write {data_in[4], data_in[3:0]} into the holding buffer when valid_in=1 and occupancy < DEPTH.
REQ-015 SHALL drop the word and set overflow=1 when valid_in=1 and occupancy == DEPTH; this applies even if a pop occurs the same cycle.
REQ-016 SHALL pop the head entry when the buffer is non-empty and the full flag for the head's VC is 0.
REQ-017 SHALL, on a pop, assert pushVCx (x = head VC id) for exactly one cycle, with dataOut_VCx = head payload, at the same edge.
REQ-018 SHALL deliver a word written into an empty buffer at edge N on push at edge N+1, so the latency is 1 cycle.
REQ-019 SHALL preserve arrival order across both VCs, so a blocked head blocks all later entries.
REQ-020 SHALL assert at most one push strobe per cycle.
REQ-021 SHALL hold dataOut_VCx at its last value while pushVCx=0.
REQ-022 SHALL allow a write and a pop in the same cycle; occupancy is then unchanged.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL register pause as (next occupancy >= AF_THRESH).
REQ-025 SHALL increment count_VCx on each pushVCx and wrap from 255 to 0.
REQ-026 SHALL implement FSM state IDLE: buffer empty.
REQ-027 SHALL implement FSM state ACTIVE: buffer non-empty and head VC not full.
REQ-028 SHALL implement FSM state STALL: buffer non-empty and head VC full.
REQ-029 SHALL use FSM transitions IDLE->ACTIVE on a write; ACTIVE->STALL when the head's full flag = 1; STALL->ACTIVE when it clears; ACTIVE->IDLE when the last entry pops with no simultaneous write.
REQ-030 SHALL evaluate fullVC0 and fullVC1 combinationally in the cycle of the pop decision.

Reset
REQ-031 SHALL, on reset_L=0, immediately clear the buffer, pointers and occupancy, and set FSM=IDLE.
REQ-032 SHALL, on reset_L=0, immediately drive pause=0, pushVC0=pushVC1=0, dataOut_VC0=dataOut_VC1=0, count_VC0=count_VC1=0, overflow=0 and idle=1.
REQ-033 SHALL discard any buffered words when reset asserts mid-operation, with no push after reset release until a new write.
REQ-034 SHALL ignore valid_in while reset_L=0.

Verification
REQ-035 SHALL cover single word: data_in=5'b1_1010 with valid for 1 cycle -> next cycle pushVC1=1 and dataOut_VC1=4'hA, pushVC0=0, count_VC1=1.
REQ-036 SHALL cover interleave: words 0_0001, 1_0010, 0_0011 on consecutive cycles, fulls=0 -> pushes VC0 1, VC1 2, VC0 3 in order with one push per cycle.
REQ-037 SHALL cover head-of-line blocking: fullVC0=1, send 0_0101 then 1_0110 -> no push, state STALL; drop fullVC0 -> VC0 5 then VC1 6.
REQ-038 SHALL cover backpressure and overflow: fullVC0=fullVC1=1, send 5 VC0 words -> pause=1 after the 3rd write, 5th word dropped, overflow=1 and stays 1.
REQ-039 SHALL cover wrap: 256 VC0 words with fulls=0 -> count_VC0 returns to 0, no drops, pointers wrap cleanly.
REQ-040 SHALL cover reset mid-stall: 3 words buffered, reset_L pulsed low -> all outputs at reset values immediately, no push after release.
